// File: rtl/usub_pkg.sv
// Shared types for the saturating unsigned down-accumulator.
package usub_pkg;

    localparam int W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SAT
    } state_t;

    typedef logic unsigned [W_DEF-1:0] uword_t;

endpackage : usub_pkg

// File: rtl/usub_5.sv
// Combinational saturating subtractor: s = max(a-b, 0), uf = borrow out.
module usub_5 #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         uf
);

    logic [W:0] diff;

    // Extend by one bit so the top bit of the difference is the borrow.
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        uf   = diff[W];
        s    = diff[W] ? '0 : diff[W-1:0];
    end

endmodule : usub_5

// File: rtl/usub_acc_5.sv
// Saturating unsigned down-accumulator with valid/ready operand intake.
// Budget is loaded once, then each accepted operand is subtracted; the
// first underflow clamps to zero and parks the block in SAT until reloaded.
module usub_acc_5
    import usub_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc,
    output logic         out_valid,
    output logic         uf,
    output logic         uf_sticky
);

    state_t       state_q;
    logic [W-1:0] acc_q;
    logic         out_valid_q;
    logic         uf_q;
    logic         uf_sticky_q;

    logic [W-1:0] sub_s;
    logic         sub_uf;
    logic         xfer;

    usub_5 #(.W(W)) u_sub (
        .a  (acc_q),
        .b  (b),
        .s  (sub_s),
        .uf (sub_uf)
    );

    // Ready depends on state alone so the source never sees a loop through in_valid.
    assign in_ready = (state_q == RUN);
    assign xfer     = in_valid && in_ready;

    // State, accumulator and result strobes. rst beats load beats a transfer;
    // an operand presented alongside load is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            uf_q        <= 1'b0;
            uf_sticky_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            uf_q        <= 1'b0;
            if (load) begin
                state_q     <= RUN;
                acc_q       <= load_val;
                uf_sticky_q <= 1'b0;
            end else if (xfer) begin
                acc_q       <= sub_s;
                out_valid_q <= 1'b1;
                uf_q        <= sub_uf;
                if (sub_uf) begin
                    uf_sticky_q <= 1'b1;
                    state_q     <= SAT;
                end
            end
        end
    end

    assign acc       = acc_q;
    assign out_valid = out_valid_q;
    assign uf        = uf_q;
    assign uf_sticky = uf_sticky_q;

endmodule : usub_acc_5
